btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner_pkg.sv | 26 ++
 rtl/btn_channel.sv | 144 ++++++++++++++
 rtl/btn_conditioner.sv | 57 +++++
 tb/tb_btn_conditioner.sv | 129 ++++++++++++
 4 files changed

// File: rtl/btn_conditioner_pkg.sv
// ============================================================================
// Module   : btn_conditioner_pkg
// Brief    : Shared timing defaults, repeat-FSM encodings and sizing helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package btn_conditioner_pkg;

    // 10 ms / 500 ms / 200 ms at 25 MHz
    localparam int c_debounce_cycles = 250000;
    localparam int c_repeat_delay    = 12500000;
    localparam int c_repeat_period   = 5000000;

    localparam int c_st_w = 2;
    localparam logic [c_st_w-1:0] c_st_idle   = 2'd0;
    localparam logic [c_st_w-1:0] c_st_delay  = 2'd1;
    localparam logic [c_st_w-1:0] c_st_repeat = 2'd2;

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_channel.sv
// ============================================================================
// Module   : btn_channel
// Brief    : One button: 2-flop sync, debounce, press pulse, optional repeat.
// Revision : 1.0
// ============================================================================
`default_nettype none

module btn_channel
    import btn_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_debounce_cycles,
    parameter int REPEAT_DELAY    = c_repeat_delay,
    parameter int REPEAT_PERIOD   = c_repeat_period,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk25M,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int c_db_w = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_db_w-1:0] c_db_max  = '1;
    localparam logic [c_db_w-1:0] c_db_one  = c_db_w'(1);

    logic [1:0]        r_sync;
    logic [c_db_w-1:0] r_db_cnt;
    logic              r_level;
    logic              r_level_d;
    logic              r_press;
    logic              w_differs;
    logic              w_accept;

    assign w_differs = (r_sync[1] != r_level);
    assign w_accept  = w_differs && (r_db_cnt == c_db_last);

    always_ff @(posedge clk25M or negedge rst) begin
        if (!rst) begin
            r_sync    <= 2'b00;
            r_db_cnt  <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], btn};
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
            if (!w_differs || w_accept) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt != c_db_max) begin
                r_db_cnt <= r_db_cnt + c_db_one;
            end
            if (w_accept) begin
                r_level <= r_sync[1];
            end
        end
    end

    if (REPEAT_EN) begin : g_repeat
        localparam int c_rc_lim = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int c_rc_w   = cnt_width(c_rc_lim);
        localparam logic [c_rc_w-1:0] c_delay_last  = c_rc_w'(REPEAT_DELAY - 1);
        localparam logic [c_rc_w-1:0] c_period_last = c_rc_w'(REPEAT_PERIOD - 1);
        localparam logic [c_rc_w-1:0] c_rc_max      = '1;
        localparam logic [c_rc_w-1:0] c_rc_one      = c_rc_w'(1);

        logic [c_st_w-1:0] r_state;
        logic [c_st_w-1:0] w_state_next;
        logic [c_rc_w-1:0] r_rcnt;
        logic [c_rc_w-1:0] w_rcnt_next;
        logic              w_fire;
        logic              r_pulse;

        always_ff @(posedge clk25M or negedge rst) begin
            if (!rst) begin
                r_state <= c_st_idle;
                r_rcnt  <= '0;
                r_pulse <= 1'b0;
            end else begin
                r_state <= w_state_next;
                r_rcnt  <= w_rcnt_next;
                r_pulse <= w_fire;
            end
        end

        // A released button leaves DELAY/REPEAT immediately, before any count match
        always_comb begin
            w_state_next = r_state;
            case (r_state)
                c_st_idle: begin
                    if (r_press) w_state_next = c_st_delay;
                end
                c_st_delay: begin
                    if (!r_level)                    w_state_next = c_st_idle;
                    else if (r_rcnt == c_delay_last) w_state_next = c_st_repeat;
                end
                c_st_repeat: begin
                    if (!r_level) w_state_next = c_st_idle;
                end
                default: w_state_next = c_st_idle;
            endcase
        end

        always_comb begin
            w_fire      = 1'b0;
            w_rcnt_next = r_rcnt;
            case (r_state)
                c_st_idle: begin
                    w_rcnt_next = '0;
                    w_fire      = r_press;
                end
                c_st_delay, c_st_repeat: begin
                    if (!r_level) begin
                        w_rcnt_next = '0;
                    end else if (r_rcnt == ((r_state == c_st_delay) ? c_delay_last : c_period_last)) begin
                        w_fire      = 1'b1;
                        w_rcnt_next = '0;
                    end else if (r_rcnt != c_rc_max) begin
                        w_rcnt_next = r_rcnt + c_rc_one;
                    end
                end
                default: w_rcnt_next = '0;
            endcase
        end

        assign pulse = r_pulse;
    end else begin : g_no_repeat
        logic r_pulse;

        always_ff @(posedge clk25M or negedge rst) begin
            if (!rst) begin
                r_pulse <= 1'b0;
            end else begin
                r_pulse <= r_press;
            end
        end

        assign pulse = r_pulse;
    end

endmodule

`default_nettype wire

// File: rtl/btn_conditioner.sv
// ============================================================================
// Module   : btn_conditioner
// Brief    : Five independent button channels; directions auto-repeat.
// Revision : 1.0
// ============================================================================
`default_nettype none

module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_debounce_cycles,
    parameter int REPEAT_DELAY    = c_repeat_delay,
    parameter int REPEAT_PERIOD   = c_repeat_period
) (
    input  logic clk25M,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_right,
    input  logic btn_left,
    input  logic btn_mark,
    output logic up,
    output logic down,
    output logic right,
    output logic left,
    output logic mark
);

    btn_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1)
    ) u_up (.clk25M(clk25M), .rst(rst), .btn(btn_up), .pulse(up));

    btn_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1)
    ) u_down (.clk25M(clk25M), .rst(rst), .btn(btn_down), .pulse(down));

    btn_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1)
    ) u_right (.clk25M(clk25M), .rst(rst), .btn(btn_right), .pulse(right));

    btn_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1)
    ) u_left (.clk25M(clk25M), .rst(rst), .btn(btn_left), .pulse(left));

    // Mark is a toggle action in the game, so holding it must not repeat
    btn_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b0)
    ) u_mark (.clk25M(clk25M), .rst(rst), .btn(btn_mark), .pulse(mark));

endmodule

`default_nettype wire

// File: tb/tb_btn_conditioner.sv
// ============================================================================
// Module   : tb_btn_conditioner
// Brief    : Directed bench for btn_conditioner with D=4, RD=20, RP=8.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_btn_conditioner;

    logic clk25M = 1'b0;
    logic rst;
    logic btn_up, btn_down, btn_right, btn_left, btn_mark;
    logic up, down, right, left, mark;

    int n_cmp = 0;
    int n_err = 0;
    logic [127:0] pm;

    always #5 clk25M = ~clk25M;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(20),
        .REPEAT_PERIOD(8)
    ) dut (
        .clk25M(clk25M), .rst(rst),
        .btn_up(btn_up), .btn_down(btn_down), .btn_right(btn_right),
        .btn_left(btn_left), .btn_mark(btn_mark),
        .up(up), .down(down), .right(right), .left(left), .mark(mark)
    );

    // Bit order everywhere: {up, down, right, left, mark}
    task automatic set_btns(input logic [4:0] v);
        {btn_up, btn_down, btn_right, btn_left, btn_mark} = v;
    endtask

    task automatic tick();
        @(posedge clk25M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Edge k of the loop is the k-th sampling edge after the stimulus starts.
    // Buttons in sel are high for k < rel (toggling every 2 cycles while k < tog);
    // sel outputs must pulse exactly at the k marked in pm, all else stays 0.
    task automatic run(input string tag, input int n, input int rel, input int tog,
                       input logic [4:0] sel, input logic [127:0] map);
        for (int k = 0; k < n; k++) begin
            set_btns(((k < rel) && ((k >= tog) || ((k / 2) % 2 == 0))) ? sel : 5'b0);
            tick();
            chk($sformatf("%s k=%0d", tag, k), {up, down, right, left, mark},
                map[k] ? sel : 5'b0);
        end
    endtask

    initial begin
        rst = 1'b0;
        set_btns(5'b0);

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_state", {up, down, right, left, mark}, 5'b0);
        end
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_after_reset", {up, down, right, left, mark}, 5'b0);
        end

        // Clean step on up, held 12 cycles: one pulse 7 edges after first sample
        pm = '0; pm[7] = 1'b1;
        run("up_step", 30, 12, 0, 5'b10000, pm);

        // Left bounces every 2 cycles for 40 cycles, then holds from k=40
        pm = '0; pm[47] = 1'b1;
        run("left_bounce", 70, 51, 40, 5'b00010, pm);

        // Right held 60 cycles from press: T=7, repeats at T+20 then every 8
        pm = '0;
        pm[7] = 1'b1; pm[27] = 1'b1; pm[35] = 1'b1;
        pm[43] = 1'b1; pm[51] = 1'b1; pm[59] = 1'b1;
        run("right_repeat", 90, 60, 0, 5'b00100, pm);

        // Mark held 100 cycles: single pulse, no repeat
        pm = '0; pm[7] = 1'b1;
        run("mark_hold", 115, 100, 0, 5'b00001, pm);

        // Up and down together
        pm = '0; pm[7] = 1'b1;
        run("up_down_same", 30, 10, 0, 5'b11000, pm);

        // Down held, reset asserted between edges at T+25 (k=32)
        pm = '0; pm[7] = 1'b1; pm[27] = 1'b1;
        run("down_pre_rst", 33, 1000, 0, 5'b01000, pm);
        #2 rst = 1'b0;
        #1 chk("down_rst_async", {up, down, right, left, mark}, 5'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("down_in_rst", {up, down, right, left, mark}, 5'b0);
        end
        rst = 1'b1;
        pm = '0; pm[7] = 1'b1;
        run("down_post_rst", 40, 20, 0, 5'b01000, pm);

        // Reset asserted during a live pulse must clear it at once
        pm = '0; pm[7] = 1'b1;
        run("right_pre_rst", 8, 1000, 0, 5'b00100, pm);
        #2 rst = 1'b0;
        #1 chk("right_rst_kill", {up, down, right, left, mark}, 5'b0);
        tick();
        chk("right_in_rst", {up, down, right, left, mark}, 5'b0);
        rst = 1'b1;
        pm = '0;
        run("right_after_rst", 15, 0, 0, 5'b00100, pm);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
